// File: rtl/max_pool_stream.sv
// rtl/max_pool_stream.sv - per-lane windowed max reducer with one-entry output buffer.
// Define MAX_POOL_ARGMAX_EN to add out_idx, the per-lane first-argmax beat index.
module max_pool_stream #(
  parameter int N_DATA   = 32,
  parameter int N_CH     = 4,
  parameter int POOL_LEN = 4,
  parameter int SIGNED   = 0,
  parameter int IDX_W    = (POOL_LEN > 1) ? $clog2(POOL_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*N_DATA-1:0] in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [N_CH*N_DATA-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_partial
`ifdef MAX_POOL_ARGMAX_EN
  ,
  output logic [N_CH*IDX_W-1:0]  out_idx
`endif
);

  logic [N_CH-1:0][N_DATA-1:0] lane;
  logic [N_CH-1:0][N_DATA-1:0] nxt_acc;
  logic [N_CH-1:0][N_DATA-1:0] acc_q, acc_d;
  logic [N_CH-1:0][N_DATA-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]            cnt_q, cnt_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_partial_q, out_partial_d;
  logic [N_CH-1:0]             gt;
  logic                        accept, last_beat, close;

  assign lane = in_data;

  for (genvar k = 0; k < N_CH; k++) begin : g_cmp
    if (SIGNED != 0) begin : g_signed
      assign gt[k] = $signed(lane[k]) > $signed(acc_q[k]);
    end else begin : g_unsigned
      assign gt[k] = lane[k] > acc_q[k];
    end
  end

  // Output register is free when empty or draining this edge.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_q == IDX_W'(POOL_LEN - 1));
  assign close     = accept && (in_last || last_beat);

  always_comb begin
    nxt_acc       = acc_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_partial_d = out_partial_q;
    for (int k = 0; k < N_CH; k++) begin
      if (cnt_q == '0 || gt[k]) nxt_acc[k] = lane[k];
    end
    if (accept) begin
      acc_d = nxt_acc;
      cnt_d = close ? '0 : cnt_q + 1'b1;
    end
    if (close) begin
      out_data_d    = nxt_acc;
      out_valid_d   = 1'b1;
      out_partial_d = in_last && !last_beat;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_partial_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_partial_q <= out_partial_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_partial = out_partial_q;

`ifdef MAX_POOL_ARGMAX_EN
  logic [N_CH-1:0][IDX_W-1:0] nxt_idx;
  logic [N_CH-1:0][IDX_W-1:0] idx_q, idx_d;
  logic [N_CH-1:0][IDX_W-1:0] out_idx_q, out_idx_d;

  // Index moves only on strict greater-than so ties keep the earliest beat.
  always_comb begin
    nxt_idx   = idx_q;
    idx_d     = idx_q;
    out_idx_d = out_idx_q;
    for (int k = 0; k < N_CH; k++) begin
      if (cnt_q == '0)  nxt_idx[k] = '0;
      else if (gt[k])   nxt_idx[k] = cnt_q;
    end
    if (accept) idx_d = nxt_idx;
    if (close)  out_idx_d = nxt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      out_idx_q <= '0;
    end else begin
      idx_q     <= idx_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign out_idx = out_idx_q;
`endif

endmodule

// File: tb/tb_max_pool_stream.sv
// tb/tb_max_pool_stream.sv - directed and scoreboard bench for max_pool_stream.
// Optional out_idx checks follow MAX_POOL_ARGMAX_EN.
module tb_max_pool_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 4 lanes x 32 bits, POOL_LEN=4, unsigned
  logic [127:0] m_in_data, m_out_data;
  logic m_in_valid, m_in_last, m_in_ready, m_out_valid, m_out_ready, m_out_partial;
  // 1 lane x 8 bits, POOL_LEN=4, signed and unsigned twins sharing inputs
  logic [7:0] b_in_data, s_out_data, u_out_data;
  logic b_in_valid, b_in_last, b_out_ready;
  logic s_in_ready, s_out_valid, s_out_partial, u_in_ready, u_out_valid, u_out_partial;
  // 4 lanes x 32 bits, POOL_LEN=1
  logic [127:0] p_in_data, p_out_data;
  logic p_in_valid, p_in_last, p_in_ready, p_out_valid, p_out_ready, p_out_partial;
`ifdef MAX_POOL_ARGMAX_EN
  logic [7:0] m_out_idx;
  logic [1:0] s_out_idx, u_out_idx;
  logic [3:0] p_out_idx;
`endif

  max_pool_stream #(.N_DATA(32), .N_CH(4), .POOL_LEN(4), .SIGNED(0)) u_main (
    .clk(clk), .rst(rst), .in_data(m_in_data), .in_valid(m_in_valid), .in_last(m_in_last),
    .in_ready(m_in_ready), .out_data(m_out_data), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .out_partial(m_out_partial)
`ifdef MAX_POOL_ARGMAX_EN
    , .out_idx(m_out_idx)
`endif
  );

  max_pool_stream #(.N_DATA(8), .N_CH(1), .POOL_LEN(4), .SIGNED(1)) u_s8 (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last),
    .in_ready(s_in_ready), .out_data(s_out_data), .out_valid(s_out_valid),
    .out_ready(b_out_ready), .out_partial(s_out_partial)
`ifdef MAX_POOL_ARGMAX_EN
    , .out_idx(s_out_idx)
`endif
  );

  max_pool_stream #(.N_DATA(8), .N_CH(1), .POOL_LEN(4), .SIGNED(0)) u_u8 (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last),
    .in_ready(u_in_ready), .out_data(u_out_data), .out_valid(u_out_valid),
    .out_ready(b_out_ready), .out_partial(u_out_partial)
`ifdef MAX_POOL_ARGMAX_EN
    , .out_idx(u_out_idx)
`endif
  );

  max_pool_stream #(.N_DATA(32), .N_CH(4), .POOL_LEN(1), .SIGNED(0)) u_p1 (
    .clk(clk), .rst(rst), .in_data(p_in_data), .in_valid(p_in_valid), .in_last(p_in_last),
    .in_ready(p_in_ready), .out_data(p_out_data), .out_valid(p_out_valid),
    .out_ready(p_out_ready), .out_partial(p_out_partial)
`ifdef MAX_POOL_ARGMAX_EN
    , .out_idx(p_out_idx)
`endif
  );

  typedef struct {
    logic [127:0] d;
    logic         p;
    logic [7:0]   idx;
  } exp_t;

  function automatic logic [127:0] pack4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [127:0] rep(input logic [31:0] v);
    return {4{v}};
  endfunction

  task automatic m_send(input logic [127:0] d, input logic l);
    @(negedge clk);
    m_in_data  = d;
    m_in_valid = 1'b1;
    m_in_last  = l;
    @(posedge clk);
  endtask

  task automatic m_idle();
    @(negedge clk);
    m_in_valid = 1'b0;
    m_in_last  = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] d, input logic l);
    @(negedge clk);
    b_in_data  = d;
    b_in_valid = 1'b1;
    b_in_last  = l;
    @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    m_in_valid = 1'b0;
    m_in_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", m_out_valid); end
    checks++; if (m_out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", m_out_data); end
    checks++; if (m_out_partial !== 1'b0) begin failures++; $display("FAIL reset_out_partial got=%b exp=0", m_out_partial); end
    checks++; if (m_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", m_in_ready); end
    checks++; if ({s_out_valid, u_out_valid, p_out_valid} !== 3'b000) begin failures++; $display("FAIL reset_aux_valid got=%b exp=000", {s_out_valid, u_out_valid, p_out_valid}); end
  endtask

  task automatic test_basic();
    m_out_ready = 1'b1;
    m_send(pack4(3, 7, 5, 0), 1'b0);
    m_send(pack4(9, 2, 5, 0), 1'b0);
    m_send(pack4(2, 9, 5, 0), 1'b0);
    #1;
    checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL basic_early got=%b exp=0", m_out_valid); end
    m_send(pack4(7, 3, 5, 1), 1'b0);
    #1;
    checks++; if (m_out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", m_out_valid); end
    checks++; if (m_out_data !== pack4(9, 9, 5, 1)) begin failures++; $display("FAIL basic_data got=%h exp=%h", m_out_data, pack4(9, 9, 5, 1)); end
    checks++; if (m_out_partial !== 1'b0) begin failures++; $display("FAIL basic_partial got=%b exp=0", m_out_partial); end
`ifdef MAX_POOL_ARGMAX_EN
    checks++; if (m_out_idx !== {2'd3, 2'd0, 2'd2, 2'd1}) begin failures++; $display("FAIL basic_idx got=%h exp=%h", m_out_idx, {2'd3, 2'd0, 2'd2, 2'd1}); end
`endif
    m_idle();
    @(posedge clk); #1;
    checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", m_out_valid); end
  endtask

  task automatic test_partial();
    m_send(rep(4), 1'b0);
    m_send(rep(6), 1'b1);
    #1;
    checks++; if (m_out_data !== rep(6) || m_out_valid !== 1'b1) begin failures++; $display("FAIL partial_data got=%h/%b exp=%h/1", m_out_data, m_out_valid, rep(6)); end
    checks++; if (m_out_partial !== 1'b1) begin failures++; $display("FAIL partial_flag got=%b exp=1", m_out_partial); end
`ifdef MAX_POOL_ARGMAX_EN
    checks++; if (m_out_idx !== 8'h55) begin failures++; $display("FAIL partial_idx got=%h exp=55", m_out_idx); end
`endif
    m_send(rep(1), 1'b0);
    m_send(rep(1), 1'b0);
    m_send(rep(1), 1'b0);
    #1;
    checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL clean_early got=%b exp=0", m_out_valid); end
    m_send(rep(1), 1'b0);
    #1;
    checks++; if (m_out_data !== rep(1) || m_out_valid !== 1'b1) begin failures++; $display("FAIL clean_data got=%h/%b exp=%h/1", m_out_data, m_out_valid, rep(1)); end
    checks++; if (m_out_partial !== 1'b0) begin failures++; $display("FAIL clean_partial got=%b exp=0", m_out_partial); end
`ifdef MAX_POOL_ARGMAX_EN
    checks++; if (m_out_idx !== 8'h00) begin failures++; $display("FAIL clean_idx got=%h exp=00", m_out_idx); end
`endif
    m_send(pack4(5, 6, 7, 8), 1'b1);
    #1;
    checks++; if (m_out_data !== pack4(5, 6, 7, 8) || m_out_partial !== 1'b1) begin failures++; $display("FAIL first_last got=%h/%b exp=%h/1", m_out_data, m_out_partial, pack4(5, 6, 7, 8)); end
    m_idle();
  endtask

  task automatic test_signed();
    b_out_ready = 1'b1;
    b_send(8'hF0, 1'b0);
    b_send(8'h05, 1'b0);
    b_send(8'h80, 1'b0);
    b_send(8'h05, 1'b0);
    #1;
    checks++; if (s_out_data !== 8'h05 || s_out_valid !== 1'b1) begin failures++; $display("FAIL signed_data got=%h/%b exp=05/1", s_out_data, s_out_valid); end
    checks++; if (u_out_data !== 8'hF0 || u_out_valid !== 1'b1) begin failures++; $display("FAIL unsigned_data got=%h/%b exp=f0/1", u_out_data, u_out_valid); end
    checks++; if (s_out_partial !== 1'b0) begin failures++; $display("FAIL signed_partial got=%b exp=0", s_out_partial); end
`ifdef MAX_POOL_ARGMAX_EN
    checks++; if (s_out_idx !== 2'd1) begin failures++; $display("FAIL signed_idx got=%0d exp=1", s_out_idx); end
    checks++; if (u_out_idx !== 2'd0) begin failures++; $display("FAIL unsigned_idx got=%0d exp=0", u_out_idx); end
`endif
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    m_out_ready = 1'b1;
    m_send(rep(10), 1'b0);
    m_send(rep(20), 1'b0);
    m_send(rep(30), 1'b0);
    m_send(rep(40), 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        m_out_ready = 1'b0;
        m_in_data   = rep(100);
        m_in_valid  = 1'b1;
        m_in_last   = 1'b0;
      end
      #1;
      checks++; if (m_in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, m_in_ready); end
      checks++; if (m_out_valid !== 1'b1 || m_out_data !== rep(40)) begin failures++; $display("FAIL stall_hold cyc=%0d got=%h/%b exp=%h/1", i, m_out_data, m_out_valid, rep(40)); end
    end
    @(negedge clk);
    m_out_ready = 1'b1;
    @(posedge clk);
    m_idle();
    checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL release_clear got=%b exp=0", m_out_valid); end
    m_send(rep(1), 1'b0);
    m_send(rep(2), 1'b0);
    m_send(rep(3), 1'b0);
    #1;
    checks++; if (m_out_valid !== 1'b1 || m_out_data !== rep(100)) begin failures++; $display("FAIL stalled_beat got=%h/%b exp=%h/1", m_out_data, m_out_valid, rep(100)); end
`ifdef MAX_POOL_ARGMAX_EN
    checks++; if (m_out_idx !== 8'h00) begin failures++; $display("FAIL stalled_idx got=%h exp=00", m_out_idx); end
`endif
    m_idle();
  endtask

  task automatic test_reset_mid();
    int n_out;
    logic [127:0] got;
    n_out = 0;
    got   = '0;
    m_out_ready = 1'b1;
    m_send(rep(9), 1'b0);
    m_send(rep(9), 1'b0);
    pulse_reset();
    for (int i = 1; i <= 4; i++) begin
      m_send(rep(32'(i)), 1'b0);
      #1;
      if (m_out_valid === 1'b1) begin n_out++; got = m_out_data; end
    end
    m_idle();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (m_out_valid === 1'b1) begin n_out++; got = m_out_data; end
    end
    checks++; if (n_out !== 1) begin failures++; $display("FAIL rst_mid_count got=%0d exp=1", n_out); end
    checks++; if (got !== rep(4)) begin failures++; $display("FAIL rst_mid_data got=%h exp=%h", got, rep(4)); end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    logic [3:0][31:0] mx;
    logic [3:0][1:0]  mi;
    logic [31:0] v;
    logic exp_ready, acc, cls;
    int cnt, beats, cyc;
    cnt = 0; beats = 0; cyc = 0;
    mx = '0; mi = '0;
    pulse_reset();
    while ((beats < 1000 || q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      m_out_ready = ($urandom_range(0, 3) != 0);
      if (beats < 1000) begin
        m_in_valid = ($urandom_range(0, 4) != 0);
        m_in_last  = ($urandom_range(0, 9) == 0);
        for (int k = 0; k < 4; k++) m_in_data[k*32 +: 32] = 32'($urandom_range(0, 15));
      end else begin
        m_in_valid = 1'b0;
        m_in_last  = 1'b0;
      end
      #1;
      exp_ready = (q.size() == 0) || m_out_ready;
      checks++; if (m_out_valid !== (q.size() != 0)) begin failures++; $display("FAIL sb_out_valid cyc=%0d got=%b exp=%b", cyc, m_out_valid, q.size() != 0); end
      checks++; if (m_in_ready !== exp_ready) begin failures++; $display("FAIL sb_in_ready cyc=%0d got=%b exp=%b", cyc, m_in_ready, exp_ready); end
      if (q.size() != 0 && m_out_ready) begin
        e = q.pop_front();
        checks++; if (m_out_data !== e.d || m_out_partial !== e.p) begin failures++; $display("FAIL sb_data cyc=%0d got=%h/%b exp=%h/%b", cyc, m_out_data, m_out_partial, e.d, e.p); end
`ifdef MAX_POOL_ARGMAX_EN
        checks++; if (m_out_idx !== e.idx) begin failures++; $display("FAIL sb_idx cyc=%0d got=%h exp=%h", cyc, m_out_idx, e.idx); end
`endif
      end
      acc = m_in_valid && exp_ready;
      if (acc) begin
        beats++;
        for (int k = 0; k < 4; k++) begin
          v = m_in_data[k*32 +: 32];
          if (cnt == 0 || v > mx[k]) begin mx[k] = v; mi[k] = 2'(cnt); end
        end
        cls = (cnt == 3) || m_in_last;
        if (cls) begin
          e.d = mx; e.p = m_in_last && (cnt != 3); e.idx = mi;
          q.push_back(e);
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
    checks++; if (beats < 1000 || q.size() != 0) begin failures++; $display("FAIL sb_timeout beats=%0d pending=%0d exp=1000/0", beats, q.size()); end
    m_idle();
  endtask

  task automatic test_pool1();
    logic prev_acc;
    logic [127:0] prev_data;
    prev_acc = 1'b0;
    prev_data = '0;
    p_out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++; if (p_out_valid !== prev_acc) begin failures++; $display("FAIL p1_valid cyc=%0d got=%b exp=%b", i, p_out_valid, prev_acc); end
      if (prev_acc) begin
        checks++; if (p_out_data !== prev_data) begin failures++; $display("FAIL p1_data cyc=%0d got=%h exp=%h", i, p_out_data, prev_data); end
        checks++; if (p_out_partial !== 1'b0) begin failures++; $display("FAIL p1_partial cyc=%0d got=%b exp=0", i, p_out_partial); end
`ifdef MAX_POOL_ARGMAX_EN
        checks++; if (p_out_idx !== 4'h0) begin failures++; $display("FAIL p1_idx cyc=%0d got=%h exp=0", i, p_out_idx); end
`endif
      end
      checks++; if (p_in_ready !== 1'b1) begin failures++; $display("FAIL p1_in_ready cyc=%0d got=%b exp=1", i, p_in_ready); end
      p_in_valid = ($urandom_range(0, 3) != 0);
      p_in_last  = ($urandom_range(0, 1) != 0);
      p_in_data  = {$urandom, $urandom, $urandom, $urandom};
      prev_acc   = p_in_valid;
      prev_data  = p_in_data;
    end
    @(negedge clk);
    p_in_valid = 1'b0;
  endtask

  initial begin
    m_in_data = '0; m_in_valid = 1'b0; m_in_last = 1'b0; m_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b1;
    p_in_data = '0; p_in_valid = 1'b0; p_in_last = 1'b0; p_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_partial();
    test_signed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_pool1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/max_pool_stream.md
Name: max_pool_stream

Overview:
- Streaming max-pooling reducer: emits the maximum of every POOL_LEN consecutively accepted input beats.
- Operates on N_CH independent lanes in parallel.
- Generalises the two-input max compare to a windowed, multi-lane, signed/unsigned, handshaked pipeline stage.
- Sits between the convolution/activation output stream and the next layer's input buffer.

Parameters:
- N_DATA, 32, lane width in bits.
- N_CH, 4, number of parallel lanes packed in one beat.
- POOL_LEN, 4, beats per pooling window; legal 1..256.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.
- IDX_W, $clog2(POOL_LEN) (minimum 1), width of window beat counter and argmax index.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_data  in  N_CH*N_DATA  input lanes; lane k = bits [k*N_DATA +: N_DATA].
- in_valid  in  1  input beat valid.
- in_last  in  1  closes the current window early on this beat (partial window).
- in_ready  out  1  block can accept a beat.
- out_data  out  N_CH*N_DATA  per-lane window maximum.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts output.
- out_partial  out  1  window was closed by in_last before POOL_LEN beats.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: out_valid=0, out_data=0, out_partial=0, beat counter=0, accumulators=0. in_ready=1 the cycle after reset deasserts.
- Reset applied mid-window or with out_valid high discards all state; no output is emitted for the discarded window.
- Handshakes:
  - Input accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is a combinational function of registered out_valid and out_ready; there is no in_valid to in_ready path.
- Per-lane accumulate on accept:
  - If counter==0, acc[k] <= lane k of in_data.
  - Otherwise acc[k] <= (lane > acc[k]) ? lane : acc[k].
  - Strict greater-than: on ties the earlier beat is retained.
- Compare: SIGNED=0 uses unsigned magnitude; SIGNED=1 uses signed compare (0x80000000 < 0x00000000 at N_DATA=32).
- Window close: an accept with counter==POOL_LEN-1, or with in_last=1, closes the window.
  - The final max, including the closing beat, is loaded into out_data the same edge.
  - out_valid <= 1 and counter <= 0.
  - out_partial <= in_last && (counter != POOL_LEN-1).
- Latency: out_valid rises 1 cycle after the closing beat is accepted.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Output buffer: one entry.
  - out_data/out_valid hold stable while out_valid && !out_ready.
  - A transfer and a new window close on the same edge reload the register, so out_valid stays 1 with no bubble.
  - A transfer with no new close clears out_valid the same edge.
- Stalling: while out_valid && !out_ready, in_ready=0. All input is stalled, including mid-window beats; the accumulators hold.
- POOL_LEN=1: every accepted beat is passed through with 1-cycle latency, out_partial=0.
- Counter: wraps only on close; never exceeds POOL_LEN-1. in_last on the first beat yields a 1-beat window with out_partial=1 (when POOL_LEN>1).

Optional Feature:
- Macro: MAX_POOL_ARGMAX_EN.
- Defined: adds output port out_idx (N_CH*IDX_W).
  - Lane k holds the beat index (0-based within the window) of the first occurrence of that lane's maximum.
  - It is tracked alongside acc, updated only on strict greater-than, and reset to 0.
  - It is registered and held exactly like out_data.
- Not defined: port absent, no index registers; all other behaviour is identical.

Test Plan:
- Unsigned, N_CH=1, POOL_LEN=4: feed 3,9,2,7 with out_ready=1 -> out_data=9 one cycle after the 4th accept, out_partial=0, out_idx=1.
- SIGNED=1, N_DATA=8: feed 0xF0,0x05,0x80,0x05 -> out_data=0x05, out_idx=1 (tie keeps first).
- Same stream with SIGNED=0 -> out_data=0xF0.
- in_last on the 2nd beat (values 4,6) -> out_data=6, out_partial=1. The next window starts clean: feed 1,1,1,1 -> out_data=1, out_partial=0.
- Backpressure: hold out_ready=0 after the first window closes -> in_ready=0 and out_data stable for 5 cycles. Then raise out_ready with the next window's beats streaming -> back-to-back outputs, no lost or duplicated beats (scoreboard over 1000 random beats).
- Assert rst mid-window after 2 beats, then feed 4 fresh beats 1,2,3,4 -> exactly one output equal to 4; no output from the pre-reset beats.
- N_CH=4, POOL_LEN=1, random data -> out_data equals in_data delayed by 1 accepted cycle, lane-independent.
